// File: rtl/osc_pkg.sv
// Shared constants for the tone oscillator path.
// Note dividers assume a 10 MHz system clock.
package osc_pkg;

  localparam int OSC_WIDTH       = 16;
  localparam int OSC_RESET_COUNT = 1;

  typedef logic [OSC_WIDTH-1:0] osc_word_t;

  localparam osc_word_t DIV_C4 = 16'd38222;
  localparam osc_word_t DIV_D4 = 16'd34052;
  localparam osc_word_t DIV_E4 = 16'd30337;
  localparam osc_word_t DIV_F4 = 16'd28635;
  localparam osc_word_t DIV_G4 = 16'd25510;
  localparam osc_word_t DIV_A4 = 16'd22727;
  localparam osc_word_t DIV_B4 = 16'd20248;
  localparam osc_word_t DIV_C5 = 16'd19111;

endpackage

// File: rtl/oscillator_counter.sv
// Programmable-period phase counter: 1..divider, then wraps.
// divider of 0 or 1 pins count at 1.
module oscillator_counter
  import osc_pkg::*;
#(
  parameter int WIDTH = OSC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] divider,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] RST_VAL =
    WIDTH'(OSC_RESET_COUNT);

  logic [WIDTH-1:0] count_d;

  // >= also catches a divider lowered below count
  always_comb begin
    count_d = count;
    if (rst) begin
      count_d = RST_VAL;
    end else if (en) begin
      if (count >= divider) begin
        count_d = RST_VAL;
      end else begin
        count_d = count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    count <= count_d;
  end

endmodule

// File: tb/tb_oscillator_counter.sv
// Directed bench for oscillator_counter.
// Expected values are hand-computed per scenario.
module tb_oscillator_counter;
  import osc_pkg::*;

  logic        tb_clk;
  logic        rst;
  logic        en;
  logic [15:0] divider;
  logic [15:0] count;

  int n_checks;
  int n_fails;

  oscillator_counter #(.WIDTH(16)) dut (
    .clk     (tb_clk),
    .rst     (rst),
    .en      (en),
    .divider (divider),
    .count   (count)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check_eq(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    en       = 1'b0;
    divider  = 16'd1;

    tick(1);
    check_eq("reset", count, 16'd1);
    rst = 1'b0;
    tick(1);
    check_eq("post_reset_hold", count, 16'd1);

    // A4 period
    divider = DIV_A4;
    en      = 1'b1;
    tick(1);
    check_eq("a4_first", count, 16'd2);
    tick(22725);
    check_eq("a4_top", count, 16'd22727);
    tick(1);
    check_eq("a4_wrap", count, 16'd1);

    divider = 16'd30000;
    tick(1);
    check_eq("d30k_first", count, 16'd2);
    tick(29998);
    check_eq("d30k_top", count, 16'd30000);
    tick(1);
    check_eq("d30k_wrap", count, 16'd1);

    // enable hold
    tick(4);
    check_eq("en_reach5", count, 16'd5);
    en = 1'b0;
    tick(10);
    check_eq("en_hold", count, 16'd5);
    en = 1'b1;
    tick(1);
    check_eq("en_resume", count, 16'd6);

    divider = 16'd1;
    tick(1);
    check_eq("div1_wrap", count, 16'd1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_eq("div1_stay", count, 16'd1);
    end
    divider = 16'd0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_eq("div0_stay", count, 16'd1);
    end

    // lower divider below count
    divider = 16'd200;
    tick(99);
    check_eq("reach100", count, 16'd100);
    divider = 16'd50;
    tick(1);
    check_eq("div_lowered", count, 16'd1);

    // mid-count reset
    divider = 16'd2000;
    tick(1233);
    check_eq("reach1234", count, 16'd1234);
    rst = 1'b1;
    tick(1);
    check_eq("mid_reset", count, 16'd1);
    rst = 1'b0;
    tick(1);
    check_eq("resume2", count, 16'd2);
    tick(1);
    check_eq("resume3", count, 16'd3);

    // raise divider mid-period
    divider = 16'd5;
    tick(1);
    check_eq("raise_pre", count, 16'd4);
    divider = 16'd10;
    tick(2);
    check_eq("raise_cont", count, 16'd6);
    tick(4);
    check_eq("raise_top", count, 16'd10);
    tick(1);
    check_eq("raise_wrap", count, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/oscillator_counter.md
# oscillator_counter

Programmable-period phase counter for the synthesizer's tone generation path. Counts from 1 up to a runtime-selected `divider`, then wraps back to 1. The wrap period sets the note frequency; e.g. `divider` = 22727 at a 10 MHz clock yields ~440 Hz (A4). Downstream waveform logic consumes `count` as a phase value.

## Interface
Parameters:
- `WIDTH`, 16, bit width of `divider` and `count`.

Ports:
- `clk`  in  1  system clock, 10 MHz nominal; all state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high. Forces `count` to 1 at the next rising edge.
- `en`  in  1  count enable. High: advance each cycle. Low: hold.
- `divider`  in  WIDTH  period / terminal count, unsigned; sampled every cycle.
- `count`  out  WIDTH  registered phase counter, range 1..`divider`.

## Operation
- `count` is the only state register.
- Priority at each rising edge of `clk`:
  - `rst` = 1: `count` <= 1.
  - else if `en` = 0: `count` holds.
  - else if `count` >= `divider`: `count` <= 1 (wrap).
  - else: `count` <= `count` + 1.
- Sequence for divider D ≥ 2 with `en` held high: 1, 2, …, D, 1, 2, … Period is exactly D cycles.
- `divider` = 1: `count` stays at 1 permanently.
- `divider` = 0: treated like 1, so `count` stays at 1. The `>=` compare covers this case.
- `divider` changed below the current `count` mid-period: wrap to 1 on the next enabled edge. `count` never exceeds max(`divider`, previous `count`) and never runs off past 2^WIDTH−1.
- `divider` raised mid-period: counting continues to the new terminal value with no discontinuity.
- `count` is never 0 after the first reset.
- `count` is X until the first reset; the design does not require a power-on value.
- Arithmetic is unsigned, WIDTH bits. The increment cannot overflow, because wrap occurs at `divider` ≤ 2^WIDTH−1.

## Timing
- `count` is a register output with no combinational path from any input.
- Latency: an `en` or `divider` change made between edges takes effect at the next rising edge.
- After `rst` is released (low before edge k), the first increment happens at edge k if `en` = 1.
- Reset asserted mid-count: `count` = 1 at the next edge, regardless of `en` or `divider`.
- Single-cycle compare plus increment; must close at 10 MHz with large margin.

## Structure
- Shared package `osc_pkg`:
  - `OSC_WIDTH` = 16.
  - `OSC_RESET_COUNT` = 1.
  - Note-divider constants, e.g. `DIV_A4` = 22727, for use by the note decoder.
- Single flat module; no sub-module is needed.
- Compare and next-state logic live in one combinational block feeding one `always_ff`.

## Test plan
- **Reset:** `rst` = 1 with `en` = 0, `divider` = 1, across one clock edge -> `count` = 1. After release and a further edge, `count` stays 1.
- **A4 divider:** `divider` = 22727, `en` = 1 after reset.
  - After 1 cycle: `count` = 2.
  - After 22726 cycles: `count` = 22727.
  - Next cycle: `count` = 1.
- **Arbitrary divider:** `divider` = 30000.
  - After 1 cycle: `count` = 2.
  - After 29999 cycles: `count` = 30000.
  - Next cycle: `count` = 1.
- **Enable hold:** count to 5, drop `en` for 10 cycles -> `count` stays 5. Re-raise `en` -> 6 on the next edge.
- **Divider edge values:** `divider` = 1 or 0 with `en` = 1 -> `count` stays 1 for 20 cycles. With `count` = 100, set `divider` = 50 -> next edge gives 1.
- **Mid-operation reset:** `count` = 1234 with `en` = 1, assert `rst` for one edge -> `count` = 1. Release -> counting resumes 2, 3, …
